// File: rtl/sparse_dot_sched_if.sv
// Bundle of the chunk input port, the Sparse datapath port and the row result port.
// The master side feeds chunks, models Sparse and consumes results; the slave side is the scheduler.
interface sparse_dot_sched_if #(
  parameter int LANES      = 16,
  parameter int DW         = 8,
  parameter int PW         = 25,
  parameter int MAX_CHUNKS = 16,
  parameter int ACCW       = PW + $clog2(MAX_CHUNKS),
  parameter int CW         = $clog2(MAX_CHUNKS) + 1
);
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*DW-1:0]   in_A;
  logic [LANES*DW-1:0]   in_B;
  logic                  in_last;
  logic [LANES*DW-1:0]   dp_A;
  logic [LANES*DW-1:0]   dp_B;
  logic [PW-1:0]         dp_result;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACCW-1:0]       out_sum;
  logic [CW-1:0]         out_chunks;
  logic [CW-1:0]         out_skipped;
  logic                  out_ovf;
  logic                  busy;

  modport master (
    output in_valid, in_A, in_B, in_last, dp_result, out_ready,
    input  in_ready, dp_A, dp_B, out_valid, out_sum, out_chunks, out_skipped, out_ovf, busy
  );

  modport slave (
    input  in_valid, in_A, in_B, in_last, dp_result, out_ready,
    output in_ready, dp_A, dp_B, out_valid, out_sum, out_chunks, out_skipped, out_ovf, busy
  );
endinterface

// File: rtl/sparse_dot_sched.sv
// Row scheduler for the Sparse dot-product datapath: skips chunks with no live lane pair,
// issues live chunks, waits LAT cycles for the product and accumulates the row sum.
module sparse_dot_sched #(
  parameter int LANES      = 16,
  parameter int DW         = 8,
  parameter int PW         = 25,
  parameter int LAT        = 3,
  parameter int MAX_CHUNKS = 16,
  parameter int ACCW       = PW + $clog2(MAX_CHUNKS),
  parameter int CW         = $clog2(MAX_CHUNKS) + 1
) (
  input  logic              clk,
  input  logic              rst,
  sparse_dot_sched_if.slave bus
);
  localparam int VW   = LANES * DW;
  localparam int LATW = $clog2(LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  state_e          state_q, state_d;
  logic [LATW-1:0] cnt_q, cnt_d;
  logic            last_q, last_d;
  logic [ACCW-1:0] acc_q, acc_d;
  logic [CW-1:0]   chunks_q, chunks_d;
  logic [CW-1:0]   skipped_q, skipped_d;
  logic            ovf_q, ovf_d;
  logic [VW-1:0]   dp_a_q, dp_a_d;
  logic [VW-1:0]   dp_b_q, dp_b_d;

  logic          live;
  logic          hs;
  logic [CW-1:0] chunks_inc;
  logic          hit_max;
  logic          row_end;

  always_comb begin
    live = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (bus.in_A[i*DW +: DW] != '0 && bus.in_B[i*DW +: DW] != '0) live = 1'b1;
    end
  end

  assign hs         = bus.in_valid && (state_q == IDLE);
  assign chunks_inc = chunks_q + 1'b1;
  assign hit_max    = (chunks_inc == CW'(MAX_CHUNKS));
  assign row_end    = bus.in_last || hit_max;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    acc_d     = acc_q;
    chunks_d  = chunks_q;
    skipped_d = skipped_q;
    ovf_d     = ovf_q;
    dp_a_d    = dp_a_q;
    dp_b_d    = dp_b_q;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          chunks_d = chunks_inc;
          if (hit_max && !bus.in_last) ovf_d = 1'b1;
          if (live) begin
            dp_a_d  = bus.in_A;
            dp_b_d  = bus.in_B;
            last_d  = row_end;
            cnt_d   = LATW'(LAT);
            state_d = WAIT;
          end else begin
            skipped_d = skipped_q + 1'b1;
            state_d   = row_end ? DONE : IDLE;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        // Expiry edge is LAT edges after the issue; dp_result is sampled exactly here.
        if (cnt_q == LATW'(1)) begin
          acc_d   = acc_q + ACCW'(bus.dp_result);
          state_d = last_q ? DONE : IDLE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          acc_d     = '0;
          chunks_d  = '0;
          skipped_d = '0;
          ovf_d     = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b0;
      acc_q     <= '0;
      chunks_q  <= '0;
      skipped_q <= '0;
      ovf_q     <= 1'b0;
      dp_a_q    <= '0;
      dp_b_q    <= '0;
    end else begin
      // NOTE: non-blocking updates keep every register sampling pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      acc_q     <= acc_d;
      chunks_q  <= chunks_d;
      skipped_q <= skipped_d;
      ovf_q     <= ovf_d;
      dp_a_q    <= dp_a_d;
      dp_b_q    <= dp_b_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.dp_A        = dp_a_q;
  assign bus.dp_B        = dp_b_q;
  assign bus.out_valid   = (state_q == DONE);
  assign bus.out_sum     = acc_q;
  assign bus.out_chunks  = chunks_q;
  assign bus.out_skipped = skipped_q;
  assign bus.out_ovf     = ovf_q;
  assign bus.busy        = (state_q != IDLE) || (chunks_q != '0);
endmodule

// File: tb/tb_sparse_dot_sched.sv
// Directed bench for sparse_dot_sched: a row table plus hand sequences for overflow,
// DONE back-pressure and asynchronous reset; Sparse is modelled as an LAT-cycle dot product.
module tb_sparse_dot_sched;
  localparam int LANES      = 16;
  localparam int DW         = 8;
  localparam int PW         = 25;
  localparam int LAT        = 3;
  localparam int MAX_CHUNKS = 16;
  localparam int ACCW       = PW + $clog2(MAX_CHUNKS);
  localparam int CW         = $clog2(MAX_CHUNKS) + 1;
  localparam int VW         = LANES * DW;

  localparam logic [VW-1:0] ALL_FF = {LANES{8'hFF}};
  localparam logic [VW-1:0] ALT_A  = {(LANES/2){16'h00FF}};
  localparam logic [VW-1:0] ALT_B  = {(LANES/2){16'hFF00}};
  localparam logic [VW-1:0] MIX_A  = {(LANES/2){16'h0102}};
  localparam logic [VW-1:0] ALL_03 = {LANES{8'h03}};
  localparam logic [VW-1:0] L5_A   = VW'(8'h10) << 40;
  localparam logic [VW-1:0] L5_B   = VW'(8'h20) << 40;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  sparse_dot_sched_if #(.LANES(LANES), .DW(DW), .PW(PW), .MAX_CHUNKS(MAX_CHUNKS),
                        .ACCW(ACCW), .CW(CW)) bus ();

  sparse_dot_sched #(.LANES(LANES), .DW(DW), .PW(PW), .LAT(LAT), .MAX_CHUNKS(MAX_CHUNKS),
                     .ACCW(ACCW), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [PW-1:0] dot(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [PW-1:0] s = '0;
    for (int i = 0; i < LANES; i++) s += PW'(a[i*DW +: DW]) * PW'(b[i*DW +: DW]);
    return s;
  endfunction

  // Sparse stand-in: result appears LAT edges after dp_A/dp_B are loaded
  logic [PW-1:0] pipe [LAT-1];
  always @(posedge clk) begin
    pipe[0] <= dot(bus.dp_A, bus.dp_B);
    for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.dp_result = pipe[LAT-2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the handshake edge.
  task automatic send_chunk(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic last,
                            output int hs_cyc, output int stalls);
    bus.in_A     = a;
    bus.in_B     = b;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    stalls       = 0;
    while (!bus.in_ready && stalls < 50) begin
      @(negedge clk);
      stalls++;
    end
    if (stalls >= 50) check("handshake_timeout", 64'(bus.in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    hs_cyc       = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int rise_cyc);
    int k = 0;
    while (!bus.out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) check("out_valid_timeout", 64'(bus.out_valid), 1);
    rise_cyc = cyc;
  endtask

  task automatic accept_result();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("accept_valid_drop", 64'(bus.out_valid), 0);
    check("accept_ready_high", 64'(bus.in_ready), 1);
    check("accept_busy_clear", 64'(bus.busy), 0);
  endtask

  typedef struct {
    int              n;
    logic [VW-1:0]   a0, b0, a1, b1;
    logic [ACCW-1:0] sum;
    int              chunks, skipped, gap, rise;
    bit              hold_dp;
  } row_t;

  row_t rows [6];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int hs0, hs1, rise, st0, st1;
    logic [VW-1:0] pre_a, pre_b;
    logic seen_valid;

    rows[0] = '{n:1, a0:ALL_FF, b0:ALL_FF, a1:'0, b1:'0, sum:1040400, chunks:1, skipped:0, gap:0, rise:3, hold_dp:0};
    rows[1] = '{n:2, a0:ALL_FF, b0:ALL_FF, a1:ALL_FF, b1:ALL_FF, sum:2080800, chunks:2, skipped:0, gap:4, rise:3, hold_dp:0};
    rows[2] = '{n:2, a0:ALL_FF, b0:'0, a1:ALT_A, b1:ALT_B, sum:0, chunks:2, skipped:2, gap:1, rise:0, hold_dp:1};
    rows[3] = '{n:2, a0:VW'(2), b0:VW'(3), a1:'0, b1:ALL_FF, sum:6, chunks:2, skipped:1, gap:4, rise:0, hold_dp:0};
    rows[4] = '{n:2, a0:ALL_FF, b0:'0, a1:L5_A, b1:L5_B, sum:512, chunks:2, skipped:1, gap:1, rise:3, hold_dp:0};
    rows[5] = '{n:1, a0:MIX_A, b0:ALL_03, a1:'0, b1:'0, sum:72, chunks:1, skipped:0, gap:0, rise:3, hold_dp:0};

    bus.in_valid  = 1'b0;
    bus.in_A      = '0;
    bus.in_B      = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state, and a live chunk offered during reset must not be taken
    @(negedge clk);
    bus.in_A = ALL_FF; bus.in_B = ALL_FF; bus.in_last = 1'b1; bus.in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 1);
    check("rst_out_valid", 64'(bus.out_valid), 0);
    check("rst_busy", 64'(bus.busy), 0);
    check("rst_dp_zero", 64'(bus.dp_A == '0 && bus.dp_B == '0), 1);
    check("rst_chunks", 64'(bus.out_chunks), 0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Table of rows
    for (int r = 0; r < 6; r++) begin
      pre_a = bus.dp_A;
      pre_b = bus.dp_B;
      send_chunk(rows[r].a0, rows[r].b0, rows[r].n == 1, hs0, st0);
      hs1 = hs0;
      st1 = 0;
      if (rows[r].n == 2) begin
        send_chunk(rows[r].a1, rows[r].b1, 1'b1, hs1, st1);
        check($sformatf("row%0d_gap", r), 64'(hs1 - hs0), 64'(rows[r].gap));
      end
      wait_done(rise);
      check($sformatf("row%0d_valid_lat", r), 64'(rise - hs1), 64'(rows[r].rise));
      check($sformatf("row%0d_sum", r), 64'(bus.out_sum), 64'(rows[r].sum));
      check($sformatf("row%0d_chunks", r), 64'(bus.out_chunks), 64'(rows[r].chunks));
      check($sformatf("row%0d_skipped", r), 64'(bus.out_skipped), 64'(rows[r].skipped));
      check($sformatf("row%0d_ovf", r), 64'(bus.out_ovf), 0);
      if (rows[r].hold_dp) begin
        check($sformatf("row%0d_dp_held", r), 64'(bus.dp_A == pre_a && bus.dp_B == pre_b), 1);
        check($sformatf("row%0d_no_stall", r), 64'(st0 + st1), 0);
      end
      accept_result();
    end

    // Force-terminated row: 16 chunks, in_last never set
    for (int c = 0; c < MAX_CHUNKS; c++) send_chunk(VW'(2), VW'(3), 1'b0, hs0, st0);
    wait_done(rise);
    check("ovf_sum", 64'(bus.out_sum), 96);
    check("ovf_flag", 64'(bus.out_ovf), 1);
    check("ovf_chunks", 64'(bus.out_chunks), 16);
    check("ovf_skipped", 64'(bus.out_skipped), 0);
    accept_result();
    check("ovf_flag_cleared", 64'(bus.out_ovf), 0);

    // DONE held under back-pressure while a chunk is offered
    send_chunk(VW'(5), VW'(7), 1'b1, hs0, st0);
    wait_done(rise);
    bus.in_A = ALL_FF; bus.in_B = ALL_FF; bus.in_last = 1'b1; bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("hold%0d_sum", c), 64'(bus.out_sum), 35);
      check($sformatf("hold%0d_valid", c), 64'(bus.out_valid), 1);
      check($sformatf("hold%0d_in_ready", c), 64'(bus.in_ready), 0);
      check($sformatf("hold%0d_chunks", c), 64'(bus.out_chunks), 1);
    end
    check("hold_dp_unchanged", 64'(bus.dp_A == VW'(5) && bus.dp_B == VW'(7)), 1);
    bus.in_valid = 1'b0;
    accept_result();
    send_chunk(VW'(1), VW'(4), 1'b1, hs0, st0);
    wait_done(rise);
    check("after_hold_sum", 64'(bus.out_sum), 4);
    accept_result();

    // Asynchronous reset in the middle of a WAIT with a partial sum already accumulated
    send_chunk(VW'(2), VW'(3), 1'b0, hs0, st0);
    send_chunk(ALL_FF, ALL_FF, 1'b0, hs1, st1);
    check("pre_reset_sum", 64'(bus.out_sum), 6);
    check("pre_reset_busy", 64'(bus.busy), 1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_dp", 64'(bus.dp_A == '0 && bus.dp_B == '0), 1);
    check("async_rst_sum", 64'(bus.out_sum), 0);
    check("async_rst_chunks", 64'(bus.out_chunks), 0);
    check("async_rst_busy", 64'(bus.busy), 0);
    check("async_rst_in_ready", 64'(bus.in_ready), 1);
    @(negedge clk);
    rst = 1'b1;
    seen_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      seen_valid |= bus.out_valid;
    end
    check("no_valid_after_reset", 64'(seen_valid), 0);
    send_chunk(VW'(9), VW'(9), 1'b1, hs0, st0);
    wait_done(rise);
    check("fresh_row_sum", 64'(bus.out_sum), 81);
    check("fresh_row_chunks", 64'(bus.out_chunks), 1);
    check("fresh_row_lat", 64'(rise - hs0), 3);
    accept_result();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
